// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the pipelined register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Architectural zero register: reads as zero, never written, never busy.
  localparam int ZERO_REG = 0;

  // Width of the busy-register population count for a given address width.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, with flush, issue and
// writeback priority, a registered busy count and a sticky WAW error flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [2**ADDR_W-1:0]     busy_o,
  output logic [cnt_w(ADDR_W)-1:0] busy_cnt,
  output logic                     err_waw
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = cnt_w(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wr_act, iss_act;

  assign wr_act  = wr_en  && (wr_addr  != ZERO_ADDR);
  assign iss_act = iss_en && (iss_addr != ZERO_ADDR) && !flush;

  // Next busy vector: writeback clears, then flush clears all, else issue sets.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    busy_d = busy_q;
    if (wr_act) busy_d[wr_addr] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end else if (iss_act) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;

    // An issue to a register still pending (and not retired this cycle) is a WAW hazard.
    err_d = err_q;
    if (iss_act && busy_q[iss_addr] && !(wr_act && (wr_addr == iss_addr))) err_d = 1'b1;

    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(busy_d[i]);
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_o   = busy_q;
  assign busy_cnt = cnt_q;
  assign err_waw  = err_q;

endmodule

// File: rtl/pipe_regfile.sv
// Multi-port register file with write-to-read bypass and pending-write scoreboard.
module pipe_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [cnt_w(ADDR_W)-1:0] busy_cnt,
  output logic                     err_waw
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_vec;

  // Register storage; writes to the zero register are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage array is reset because registers must read zero after reset.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_o   (busy_vec),
    .busy_cnt (busy_cnt),
    .err_waw  (err_waw)
  );

  // One combinational read port per generate iteration: zero reg, bypass, then storage.
  // Outputs are held at zero while reset is asserted, even if a write is presented.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit;

    assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
    assign is_zero = (addr == ZERO_ADDR);
    assign hit     = wr_en && (wr_addr == addr);

    assign rd_data[p*DATA_W +: DATA_W] = (!rst_n || is_zero) ? '0 :
                                         hit ? wr_data : mem_q[addr];
    assign rd_busy[p] = rst_n && !is_zero && !hit && busy_vec[addr];
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// Self-checking bench for pipe_regfile: behavioural model plus directed vectors.
module tb_pipe_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 2**AW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic            flush;
  logic [AW:0]     busy_cnt;
  logic            err_waw;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_cnt (busy_cnt),
    .err_waw  (err_waw)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
      m_err <= 1'b0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr]  <= wr_data;
        m_busy[wr_addr] <= 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] <= 1'b0;
      end else if (iss_en && iss_addr != 0) begin
        m_busy[iss_addr] <= 1'b1;
        if (m_busy[iss_addr] && !(wr_en && wr_addr == iss_addr)) m_err <= 1'b1;
      end
    end
  end

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Compare process: every mid-cycle, all outputs against the model.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d;
    logic          exp_b;
    for (int p = 0; p < NR; p++) begin
      a = rd_addr[p*AW +: AW];
      if (!rst_n || a == 0) begin
        exp_d = '0; exp_b = 1'b0;
      end else if (wr_en && wr_addr == a) begin
        exp_d = wr_data; exp_b = 1'b0;
      end else begin
        exp_d = m_reg[a]; exp_b = m_busy[a];
      end
      check($sformatf("model rd_data[%0d] a=%0d", p, a), 64'(rd_data[p*DW +: DW]), 64'(exp_d));
      check($sformatf("model rd_busy[%0d] a=%0d", p, a), 64'(rd_busy[p]), 64'(exp_b));
    end
    check("model busy_cnt", 64'(busy_cnt), 64'(model_count()));
    check("model err_waw", 64'(err_waw), 64'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    rd(0, 0);
    repeat (2) advance();
    rst_n = 1'b1;
    advance();

    // Reset asserted in the middle of a write to r8.
    wr_en = 1; wr_addr = 8; wr_data = 32'hDEADBEEF; rd(8, 8);
    settle();
    rst_n = 1'b0;
    #1;
    check("reset rd_data r8", 64'(port_data(0)), 64'h0);
    check("reset busy_cnt", 64'(busy_cnt), 64'h0);
    check("reset err_waw", 64'(err_waw), 64'h0);
    advance();
    idle();
    rst_n = 1'b1;
    settle();
    check("post-reset r8", 64'(port_data(0)), 64'h0);
    advance();

    // Bypass on both ports, then stored value.
    wr_en = 1; wr_addr = 9; wr_data = 32'h12345678; rd(9, 9);
    settle();
    check("bypass p0 r9", 64'(port_data(0)), 64'h12345678);
    check("bypass p1 r9", 64'(port_data(1)), 64'h12345678);
    advance();
    idle();
    settle();
    check("stored p0 r9", 64'(port_data(0)), 64'h12345678);
    check("stored p1 r9", 64'(port_data(1)), 64'h12345678);
    advance();

    // Zero register ignores writes and issues.
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; rd(0, 0);
    settle();
    check("r0 bypass blocked", 64'(port_data(0)), 64'h0);
    check("r0 busy", 64'(rd_busy), 64'h0);
    advance();
    idle();
    settle();
    check("r0 read", 64'(port_data(1)), 64'h0);
    check("r0 busy_cnt", 64'(busy_cnt), 64'h0);
    advance();

    // Issue r10, then retire it.
    iss_en = 1; iss_addr = 10; rd(10, 9);
    settle();
    check("r10 busy same cycle", 64'(rd_busy[0]), 64'h0);
    advance();
    idle();
    settle();
    check("r10 busy next", 64'(rd_busy[0]), 64'h1);
    check("r10 busy_cnt", 64'(busy_cnt), 64'h1);
    advance();
    wr_en = 1; wr_addr = 10; wr_data = 32'hA;
    settle();
    check("r10 busy cleared same cycle", 64'(rd_busy[0]), 64'h0);
    check("r10 busy_cnt before edge", 64'(busy_cnt), 64'h1);
    advance();
    idle();
    settle();
    check("r10 busy_cnt after write", 64'(busy_cnt), 64'h0);
    advance();

    // Simultaneous issue and write to r11: issue wins.
    wr_en = 1; wr_addr = 11; wr_data = 32'hB11; iss_en = 1; iss_addr = 11; rd(11, 10);
    advance();
    idle();
    settle();
    check("r11 data", 64'(port_data(0)), 64'hB11);
    check("r11 busy", 64'(rd_busy[0]), 64'h1);
    check("r11 busy_cnt", 64'(busy_cnt), 64'h1);
    check("r11 err before", 64'(err_waw), 64'h0);
    advance();
    iss_en = 1; iss_addr = 11;
    advance();
    idle();
    settle();
    check("waw err set", 64'(err_waw), 64'h1);
    advance();
    settle();
    check("waw err sticky", 64'(err_waw), 64'h1);
    advance();

    // Retire r11, issue r12..r15, then flush with a simultaneous issue to r16.
    wr_en = 1; wr_addr = 11; wr_data = 32'hC11;
    advance();
    idle();
    for (int r = 12; r <= 15; r++) begin
      iss_en = 1; iss_addr = AW'(r);
      advance();
    end
    idle();
    settle();
    check("four busy", 64'(busy_cnt), 64'h4);
    advance();
    flush = 1; iss_en = 1; iss_addr = 16;
    advance();
    idle();
    rd(16, 9);
    settle();
    check("flush busy_cnt", 64'(busy_cnt), 64'h0);
    check("flush r16 busy", 64'(rd_busy[0]), 64'h0);
    check("flush keeps r9", 64'(port_data(1)), 64'h12345678);
    check("flush keeps err", 64'(err_waw), 64'h1);
    rd(11, 12);
    #1;
    check("flush keeps r11", 64'(port_data(0)), 64'hC11);
    advance();

    // Back-to-back mixed traffic on a small address range, checked by the model.
    for (int n = 0; n < 60; n++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 9) == 0);
      rd($urandom_range(0, 7), $urandom_range(0, 7));
      advance();
    end
    idle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
